// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the default index width.
package branch_predictor_pkg;

    localparam int BP_IDX_W = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline <-> predictor signal bundle: IF lookup, EX training and the
// mispredict redirect.
interface branch_predictor_if;

    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        ex_is_br;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_br;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    logic        mispredict;
    logic [31:0] redirect_pc;

    modport master (
        output if_pc, ex_is_br, ex_pc, ex_target, ex_br, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, ex_is_br, ex_pc, ex_target, ex_br, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next-state function of a 2-bit saturating branch counter.
module bp_sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctr_next
);

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ctr_next = ctr;
        unique case (ctr)
            SNT: ctr_next = taken ? WNT : SNT;
            WNT: ctr_next = taken ? WT  : SNT;
            WT:  ctr_next = taken ? ST  : WNT;
            ST:  ctr_next = taken ? ST  : WT;
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational IF lookup,
// EX-stage training and mispredict redirect. Define BP_STATS_EN for counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predictor_if.slave   bus
`ifdef BP_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispred
`endif
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic              valid_q  [ENTRIES];
    ctr_e              ctr_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];

    // ---------------- lookup (IF) ----------------
    logic [IDX_W-1:0] lu_idx;
    logic [TAG_W-1:0] lu_tag;
    logic             lu_hit;

    assign lu_idx = bus.if_pc[IDX_W+1:2];
    assign lu_tag = bus.if_pc[31:IDX_W+2];
    assign lu_hit = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);

    // Reads the pre-update table; a same-cycle write to this index is not bypassed.
    assign bus.pred_taken  = rst_n && lu_hit && ctr_q[lu_idx][1];
    assign bus.pred_target = bus.pred_taken ? target_q[lu_idx] : pc_plus4(bus.if_pc);

    // ---------------- resolution (EX) ----------------
    logic dir_wrong;
    logic tgt_wrong;

    assign dir_wrong = bus.ex_br != bus.ex_pred_taken;
    assign tgt_wrong = bus.ex_br && bus.ex_pred_taken && (bus.ex_pred_target != bus.ex_target);

    assign bus.mispredict  = rst_n && bus.ex_is_br && (dir_wrong || tgt_wrong);
    assign bus.redirect_pc = bus.ex_br ? bus.ex_target : pc_plus4(bus.ex_pc);

    // ---------------- training ----------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    ctr_e             up_ctr_next;

    assign up_idx = bus.ex_pc[IDX_W+1:2];
    assign up_tag = bus.ex_pc[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    bp_sat_counter2 u_sat_counter (
        .ctr      (ctr_q[up_idx]),
        .taken    (bus.ex_br),
        .ctr_next (up_ctr_next)
    );

    // NOTE: state is written with non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (bus.ex_is_br) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_next;
            end else if (bus.ex_br) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= WT;
            end
        end
    end

    // NOTE: tag and target storage carries no reset; a cleared valid bit already
    // masks it, which keeps these arrays mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (bus.ex_is_br && bus.ex_br) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bus.ex_target;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (bus.ex_is_br)   stat_branches <= stat_branches + 32'd1;
            if (bus.mispredict) stat_mispred  <= stat_mispred + 32'd1;
        end
    end
`endif

    // Word-aligned PCs: the byte-offset bits carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic against a behavioural BTB model, checked through a scoreboard queue.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int IDX_W = BP_IDX_W;
    localparam int N     = 1 << IDX_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if bus ();

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BP_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    typedef struct {
        int          cyc;
        bit          taken;
        logic [31:0] target;
        bit          misp;
        bit          chk_redir;
        logic [31:0] redir;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Behavioural model: each slot remembers which PC owns it.
    bit          m_valid  [N];
    logic [31:0] m_owner  [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    int          n_br;
    int          n_misp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && ((m_owner[i] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
    endfunction

    task automatic m_lookup(input logic [31:0] pc, output bit taken, output logic [31:0] tgt);
        int i = idx_of(pc);
        taken = m_hit(pc) && (m_ctr[i] >= 2);
        tgt   = taken ? m_target[i] : pc + 32'd4;
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        n_br   = 0;
        n_misp = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("pred_taken@%0d", e.cyc), {31'b0, bus.pred_taken}, {31'b0, e.taken});
            check($sformatf("pred_target@%0d", e.cyc), bus.pred_target, e.target);
            check($sformatf("mispredict@%0d", e.cyc), {31'b0, bus.mispredict}, {31'b0, e.misp});
            if (e.chk_redir)
                check($sformatf("redirect_pc@%0d", e.cyc), bus.redirect_pc, e.redir);
        end
    end

    // One cycle: drive inputs, push the expectation, then advance the model
    // past the coming clock edge.
    task automatic step(input bit is_br, input logic [31:0] ifpc, input logic [31:0] expc,
                        input logic [31:0] extgt, input bit br, input bit ptk,
                        input logic [31:0] ptgt);
        exp_t e;
        bit   misp;
        int   i;
        bus.if_pc          = ifpc;
        bus.ex_is_br       = is_br;
        bus.ex_pc          = expc;
        bus.ex_target      = extgt;
        bus.ex_br          = br;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptgt;

        misp = is_br && ((br != ptk) || (br && ptk && (ptgt != extgt)));
        e.cyc = cyc;
        if (rst_n) begin
            m_lookup(ifpc, e.taken, e.target);
            e.misp      = misp;
            e.chk_redir = 1'b1;
        end else begin
            e.taken     = 1'b0;
            e.target    = ifpc + 32'd4;
            e.misp      = 1'b0;
            e.chk_redir = 1'b0;
        end
        e.redir = br ? extgt : expc + 32'd4;
        exp_q.push_back(e);

        if (rst_n && is_br) begin
            n_br++;
            if (misp) n_misp++;
            i = idx_of(expc);
            if (m_hit(expc)) begin
                m_ctr[i] = br ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                              : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (br) m_target[i] = extgt;
            end else if (br) begin
                m_valid[i]  = 1'b1;
                m_owner[i]  = expc;
                m_target[i] = extgt;
                m_ctr[i]    = 2;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic lookup(input logic [31:0] ifpc);
        step(1'b0, ifpc, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tag;
        tag = ($urandom_range(0, 9) == 0) ? 32'hFFFFFF : 32'($urandom_range(0, 3));
        return (tag << (IDX_W + 2)) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        bit          ptk;
        logic [31:0] ptgt;
        logic [31:0] pc;

        bus.if_pc = '0; bus.ex_is_br = 1'b0; bus.ex_pc = '0; bus.ex_target = '0;
        bus.ex_br = 1'b0; bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 32'h100, 32'h200, 32'h180, 1'b1, 1'b0, 32'h204); // in reset: all quiet
        rst_n = 1'b1;

        lookup(32'h100);
        // Cold taken branch, then predicted taken
        step(1'b1, 32'h100, 32'h200, 32'h180, 1'b1, 1'b0, 32'h204);
        lookup(32'h200);
        // Saturation: 4 taken, 1 not-taken still taken, 2nd not-taken flips
        for (int k = 0; k < 4; k++) step(1'b1, 32'h200, 32'h200, 32'h180, 1'b1, 1'b1, 32'h180);
        step(1'b1, 32'h200, 32'h200, 32'h180, 1'b0, 1'b1, 32'h180);
        lookup(32'h200);
        step(1'b1, 32'h200, 32'h200, 32'h180, 1'b0, 1'b1, 32'h180);
        lookup(32'h200);
        // Target change
        step(1'b1, 32'h200, 32'h200, 32'h180, 1'b1, 1'b0, 32'h204);
        step(1'b1, 32'h200, 32'h200, 32'h180, 1'b1, 1'b1, 32'h180);
        lookup(32'h200);
        step(1'b1, 32'h200, 32'h200, 32'h1C0, 1'b1, 1'b1, 32'h180);
        lookup(32'h200);
        // Alias eviction with same-cycle lookup of the allocating PC
        step(1'b1, 32'h300, 32'h300, 32'h340, 1'b1, 1'b0, 32'h304);
        lookup(32'h200);
        lookup(32'h300);
        // Not-taken miss does not allocate; wraparound
        step(1'b1, 32'h400, 32'h400, 32'h480, 1'b0, 1'b0, 32'h404);
        lookup(32'h400);
        lookup(32'hFFFF_FFFC);
        step(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 32'h0);
        // ex_is_br low ignores the EX fields entirely
        step(1'b0, 32'h300, 32'h300, 32'h999, 1'b1, 1'b0, 32'h0);
        lookup(32'h300);

        // Asynchronous mid-run reset
        rst_n = 1'b0;
        m_reset();
        step(1'b1, 32'h100, 32'h300, 32'h340, 1'b1, 1'b0, 32'h304);
        step(1'b0, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        lookup(32'h300);
        lookup(32'h200);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            pc = rand_pc();
            m_lookup(pc, ptk, ptgt);
            if ($urandom_range(0, 3) == 0) begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = $urandom_range(0, 1) ? ptgt : {$urandom, 2'b00} >> 2 << 2;
            end
            step(1'($urandom_range(0, 9) < 7), rand_pc(), pc,
                 rand_pc() ^ 32'h0001_0000, 1'($urandom_range(0, 1)), ptk, ptgt);
        end

`ifdef BP_STATS_EN
        check("stat_branches", stat_branches, 32'(n_br));
        check("stat_mispred", stat_mispred, 32'(n_misp));
`endif

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the RV32I pipeline: direct-mapped BTB with a 2-bit saturating counter per entry.
- Looked up combinationally in IF with the fetch PC.
- Trained in EX from the branch outcome `br` produced by BranchDecision.
- Drives the mispredict flush and the redirect PC into the NPC generator / hazard unit.

Parameters:
- IDX_W, 6: index bits; ENTRIES = 2**IDX_W; index = pc[IDX_W+1:2].
- TAG_W, 32-IDX_W-2: tag bits; tag = pc[31:IDX_W+2].

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  32  fetch-stage PC for lookup.
- pred_taken  out  1  predict taken for if_pc.
- pred_target  out  32  predicted target; equals if_pc+4 when pred_taken=0.
- ex_is_br  in  1  EX holds a conditional branch (br_type != NOBRANCH) and EX is not bubbled.
- ex_pc  in  32  PC of the EX instruction.
- ex_target  in  32  computed branch target (pc+imm).
- ex_br  in  1  actual outcome from BranchDecision.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  32  predicted target carried with the instruction.
- mispredict  out  1  flush IF/ID and ID/EX, redirect fetch.
- redirect_pc  out  32  correct next PC: ex_target if ex_br, else ex_pc+4.

Behaviour:
- Storage per entry: valid (1b), tag (TAG_W), target (32), ctr (2b).
- Only valid bits and ctr are reset: on rst_n=0, immediately and asynchronously, valid=0 and ctr=2'b01 (weakly not-taken). Tag/target need no reset.
- Outputs during reset: pred_taken=0, pred_target=if_pc+4, mispredict=0.
- Lookup is combinational, zero cycles. Hit = valid[idx] & tag match.
  - pred_taken = hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4.
- Mispredict is combinational from EX inputs:
  - mispredict = ex_is_br & ((ex_br != ex_pred_taken) | (ex_br & ex_pred_taken & ex_pred_target != ex_target)).
  - When ex_is_br=0, mispredict=0 regardless of the other inputs.
- Update is registered and takes effect on the clk edge while ex_is_br=1, using index/tag of ex_pc.
  - Entry hit (valid & tag match): ctr saturating +1 if ex_br, saturating -1 otherwise (11 stays 11, 00 stays 00). Target is overwritten with ex_target if ex_br.
  - Entry miss, ex_br=1: allocate valid=1, tag, target=ex_target, ctr=2'b10 (weakly taken). This replaces any prior occupant.
  - Entry miss, ex_br=0: no allocation, no state change.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. No write-through bypass.
- Pipeline stalls need no port: the lookup is stateless and the upstream logic holds if_pc.
- ex_is_br must be low for flushed/bubbled instructions. The block trusts this input.
- All PC arithmetic is modulo 2^32: if_pc+4 wraps 0xFFFFFFFC to 0x00000000.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispred[31:0].
  - stat_branches increments on every cycle with ex_is_br=1; stat_mispred increments when mispredict=1.
  - Both reset to 0 asynchronously and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Add to Parameters.v: counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11, plus BP_IDX_W default 6.
- One sub-module: bp_sat_counter2, a combinational 2-bit saturating next-state function (inputs ctr, taken; output ctr_next), instantiated once in the update path.

Test Plan:
- Reset: rst_n=0 mid-run, if_pc=0x100 -> pred_taken=0, pred_target=0x104; after release all lookups miss.
- Cold taken branch:
  - ex_is_br=1, ex_pc=0x200, ex_target=0x180, ex_br=1, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x180.
  - Next cycle, if_pc=0x200 -> pred_taken=1, pred_target=0x180.
- Counter saturation:
  - Four taken updates at 0x200, then one not-taken -> still predicts taken (ctr=10).
  - A second not-taken -> predicts not-taken, pred_target=0x204.
- Target change: entry at 0x200 predicts 0x180; EX reports ex_br=1, ex_target=0x1C0, ex_pred_target=0x180 -> mispredict=1, redirect_pc=0x1C0; table target becomes 0x1C0.
- Alias/same-cycle:
  - 0x200 and 0x300 share an index (IDX_W=6); taken update of 0x300 evicts 0x200, so lookup 0x200 misses.
  - Lookup of 0x300 in the same cycle as its first allocation returns pred_taken=0.
- Not-taken no-alloc / wrap:
  - ex_br=0 at 0x400 with no entry -> mispredict=0, no allocation.
  - if_pc=0xFFFFFFFC -> pred_target=0x00000000.
  - Under BP_STATS_EN, the counters match the number of branches and mispredicts issued.
